fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline buffer.
- Owns the fetch PC and issues in-order word requests to a variable-latency instruction memory.
- Buffers returned instructions in a small prefetch FIFO and presents {pc+4, instruction} pairs to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_queue.sv | 158 +++++++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch front end
// Rev 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : register-based synchronous FIFO with push, pop and flush
// Rev 1.0
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign count = r_count;
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so push-on-full is accepted then
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : fetch PC owner, in-order imem requester and prefetch buffer
// Rev 1.0
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr
);

    localparam logic [CNT_W:0] c_credit_max = (CNT_W + 1)'(DEPTH);

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_fetch_pc, w_fetch_pc_nxt;
    logic [CNT_W-1:0]   r_outstanding, w_outstanding_nxt;
    logic [CNT_W-1:0]   r_stale, w_stale_nxt;

    fetch_entry_t       w_rsp_entry;
    fetch_entry_t       w_head;
    logic [CNT_W-1:0]   w_data_count;
    logic               w_data_full;
    logic               w_data_empty;
    logic [31:0]        w_tag_head;
    logic [CNT_W-1:0]   w_tag_count;
    logic               w_tag_full;
    logic               w_tag_empty;
    logic               w_unused_status;

    logic               w_in_run;
    logic               w_accept;
    logic               w_flush;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W:0]     w_credit_used;

    assign w_in_run      = (r_state == RUN);
    // Buffered plus in-flight words never exceed DEPTH, so the data FIFO cannot overflow
    assign w_credit_used = {1'b0, w_data_count} + {1'b0, r_outstanding};

    assign imem_req_valid = w_in_run && (w_credit_used < c_credit_max);
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_flush     = w_in_run && redirect_valid;
    assign w_push      = w_in_run && imem_rsp_valid && !redirect_valid;
    assign w_pop       = id_valid && id_ready;
    assign w_rsp_entry = '{pc_plus4: w_tag_head, instr: imem_rsp_data};

    assign id_valid    = w_in_run && !w_data_empty;
    assign id_pc_plus4 = w_head.pc_plus4;
    assign id_instr    = w_head.instr;

    assign w_unused_status = ^{w_data_full, w_tag_count, w_tag_full};

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_data_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_rsp_entry),
        .pop       (w_pop),
        .flush     (w_flush),
        .head      (w_head),
        .count     (w_data_count),
        .full      (w_data_full),
        .empty     (w_data_empty)
    );

    // Tag FIFO carries pc+4 of each accepted request until its response returns
    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_accept),
        .push_data (r_fetch_pc + PC_INC),
        .pop       (w_in_run && imem_rsp_valid && !w_tag_empty),
        .flush     (w_flush),
        .head      (w_tag_head),
        .count     (w_tag_count),
        .full      (w_tag_full),
        .empty     (w_tag_empty)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_outstanding_nxt = r_outstanding;
        w_stale_nxt       = r_stale;

        if (w_accept) begin
            w_outstanding_nxt = w_outstanding_nxt + CNT_W'(1);
        end
        if (imem_rsp_valid && (r_outstanding != '0)) begin
            w_outstanding_nxt = w_outstanding_nxt - CNT_W'(1);
        end

        case (r_state)
            IDLE: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (w_accept) begin
                    w_fetch_pc_nxt = r_fetch_pc + PC_INC;
                end
                if (redirect_valid) begin
                    w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
                    w_stale_nxt    = w_outstanding_nxt;
                    w_state_nxt    = (w_outstanding_nxt != '0) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
                end
                if (imem_rsp_valid && (r_stale != '0)) begin
                    w_stale_nxt = r_stale - CNT_W'(1);
                    if (r_stale == CNT_W'(1)) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_stale       <= w_stale_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : randomized scoreboard bench for fetch_queue
// Rev 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr)
    );

    // Memory transactions in flight; live=0 once a redirect has made them stale
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          live;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        int          cyc;
    } exp_t;

    mem_req_t    inflight[$];
    exp_t        expq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] model_pc = RESET_PC;
    int          ready_pct, idready_pct, redirect_pct, max_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus plus the reference model, called 1ns after posedge
    task automatic step(input bit idle);
        bit          draining, exp_req, rdy, acc, rsp, redir;
        logic [31:0] tgt;
        mem_req_t    f, n;
        exp_t        e;
        cyc++;
        draining = 1'b0;
        foreach (inflight[i]) if (!inflight[i].live) draining = 1'b1;
        exp_req = !idle && !draining && ((expq.size() + inflight.size()) < DEPTH);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        if (exp_req && imem_req_valid) check("req_addr", imem_req_addr, model_pc);

        rdy   = ($urandom_range(0, 99) < ready_pct);
        acc   = imem_req_valid && rdy;
        rsp   = (inflight.size() > 0) && (inflight[0].due <= cyc);
        redir = !idle && ($urandom_range(0, 99) < redirect_pct);
        case ($urandom_range(0, 3))
            0:       tgt = 32'h0000_0100;
            1:       tgt = 32'h0000_0200;
            2:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 3));
            default: tgt = $urandom;
        endcase

        imem_rsp_data = rsp ? inflight[0].data : $urandom;
        if (rsp) begin
            f = inflight.pop_front();
            if (f.live && !redir) begin
                e.pc_plus4 = f.addr + 32'd4;
                e.instr    = f.data;
                e.cyc      = cyc;
                expq.push_back(e);
            end
        end
        if (acc) begin
            n.addr = model_pc;
            n.data = $urandom;
            n.due  = cyc + int'($urandom_range(1, max_lat));
            n.live = 1'b1;
            inflight.push_back(n);
            model_pc = model_pc + 32'd4;
        end
        if (redir) begin
            foreach (inflight[i]) inflight[i].live = 1'b0;
            expq.delete();
            model_pc = tgt & ~32'h3;
        end

        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        redirect_valid = redir;
        redirect_pc    = tgt;
        id_ready       = ($urandom_range(0, 99) < idready_pct);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_id_pc_plus4", id_pc_plus4, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every decode handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !redirect_valid) begin
                if (expq.size() == 0) begin
                    check("id_valid_when_empty", {31'b0, id_valid}, 32'd0);
                end else if (expq[0].cyc >= cyc) begin
                    check("id_valid_early", {31'b0, id_valid}, 32'd0);
                end else begin
                    check("id_valid_stall", {31'b0, id_valid}, 32'd1);
                    if (id_valid && id_ready) begin
                        e = expq.pop_front();
                        check("id_pc_plus4", id_pc_plus4, e.pc_plus4);
                        check("id_instr", id_instr, e.instr);
                    end
                end
            end
        end
    end

    // Phase table: ready%, id_ready%, redirect%, max latency, cycles
    int phases [8][5] = '{
        '{100, 100,  0, 1,  30},
        '{100,   0,  0, 1,  12},
        '{100, 100,  0, 1,  12},
        '{100, 100,  6, 3, 150},
        '{ 60,  50, 15, 4, 400},
        '{100, 100, 25, 1, 250},
        '{ 80,  70, 10, 3, 300},
        '{100, 100,  5, 2, 200}
    };

    initial begin
        ready_pct = 100; idready_pct = 100; redirect_pct = 0; max_lat = 1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        step(1'b1);
        for (int p = 0; p < 8; p++) begin
            ready_pct    = phases[p][0];
            idready_pct  = phases[p][1];
            redirect_pct = phases[p][2];
            max_lat      = phases[p][3];
            for (int c = 0; c < phases[p][4]; c++) begin
                @(posedge clk);
                #1;
                step(1'b0);
            end
            if (p == 6) begin
                // Half-cycle reset pulse in the middle of traffic
                #1;
                rst_n = 1'b0;
                inflight.delete();
                expq.delete();
                model_pc       = RESET_PC;
                imem_req_ready = 1'b0;
                imem_rsp_valid = 1'b0;
                redirect_valid = 1'b0;
                id_ready       = 1'b0;
                #1;
                check_reset_outputs();
                #4;
                rst_n = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
